bcd_tm1638_tx: RTL

- Downstream consumer of the 3-digit BCD counter output (12-bit packed BCD: hundreds[11:8], tens[7:4], ones[3:0]).
- Converts each digit to a 7-segment code and serially refreshes a TM1638 display board over STB/CLK/DIO. The board is write-only; no key scan.
- Sends a full refresh frame after reset and whenever the BCD value changes.

---
 rtl/bcd_tm1638_tx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_tm1638_tx.sv
// Refreshes a TM1638 board with a 3-digit packed BCD value over STB/CLK/DIO.
// Define BCD_TM1638_LZB_EN to blank leading zeros on the hundreds/tens grids.
module bcd_tm1638_tx #(
    parameter int         CLK_DIV    = 4,
    parameter logic [2:0] BRIGHTNESS = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] dec_in,
    output logic        busy,
    output logic        done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB_SETUP,
        S_SHIFT,
        S_NEXT_BYTE,
        S_STB_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h40;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] grid_byte(input logic [2:0] g,
                                             input logic [11:0] v);
        logic [7:0] h;
        logic [7:0] t;
        logic [7:0] o;
        logic [7:0] r;
        h = seg7(v[11:8]);
        t = seg7(v[7:4]);
        o = seg7(v[3:0]);
`ifdef BCD_TM1638_LZB_EN
        if (v[11:8] == 4'd0) h = 8'h00;
        if (v[11:4] == 8'd0) t = 8'h00;
`endif
        case (g)
            3'd5:    r = h;
            3'd6:    r = t;
            3'd7:    r = o;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // T2 index 0 is the address command; index k>0 is display address k-1.
    function automatic logic [7:0] frame_byte(input logic [1:0]  tx,
                                              input logic [4:0]  idx,
                                              input logic [11:0] v);
        logic [3:0] addr;
        logic [7:0] r;
        addr = 4'(idx - 5'd1);
        case (tx)
            2'd0: r = 8'h40;
            2'd1: begin
                if (idx == 5'd0)  r = 8'hC0;
                else if (addr[0]) r = 8'h00;
                else              r = grid_byte(addr[3:1], v);
            end
            default: r = 8'h88 | {5'd0, BRIGHTNESS};
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    byte_q, byte_d;
    logic [1:0]    tx_q, tx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   last_val_q, last_val_d;
    logic          pending_q, pending_d;
    logic          stb_q, stb_d;
    logic          sclk_q, sclk_d;
    logic          dio_q, dio_d;

    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;
    logic       last_byte;

    always_comb begin
        cur_byte  = frame_byte(tx_q, byte_q, shadow_q);
        nxt_byte  = frame_byte(tx_q, byte_q + 5'd1, shadow_q);
        last_byte = (tx_q != 2'd1) || (byte_q == 5'd16);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        shadow_d   = shadow_q;
        last_val_d = last_val_q;
        pending_d  = pending_q | (dec_in != last_val_q);
        stb_d      = stb_q;
        sclk_d     = sclk_q;
        dio_d      = dio_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                stb_d  = 1'b1;
                sclk_d = 1'b1;
                dio_d  = 1'b1;
                if (pending_q) begin
                    state_d    = S_STB_SETUP;
                    shadow_d   = dec_in;
                    last_val_d = dec_in;
                    pending_d  = 1'b0;
                    tx_d       = 2'd0;
                    byte_d     = 5'd0;
                    stb_d      = 1'b0;
                end
            end
            S_STB_SETUP: begin
                if (cnt_q == HALF_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                    dio_d   = cur_byte[0];
                end
            end
            S_SHIFT: begin
                if (cnt_q == HALF_M1) begin
                    sclk_d = 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_NEXT_BYTE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    bit_d  = bit_q + 3'd1;
                    sclk_d = 1'b0;
                    dio_d  = cur_byte[bit_q + 3'd1];
                end
            end
            // High half of bit 7; decides whether the transaction goes on.
            S_NEXT_BYTE: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (last_byte) begin
                        state_d = S_STB_HOLD;
                    end else begin
                        state_d = S_SHIFT;
                        byte_d  = byte_q + 5'd1;
                        bit_d   = 3'd0;
                        sclk_d  = 1'b0;
                        dio_d   = nxt_byte[0];
                    end
                end
            end
            S_STB_HOLD: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    dio_d   = 1'b1;
                    state_d = (tx_q == 2'd2) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == FULL_M1) begin
                    state_d = S_STB_SETUP;
                    cnt_d   = '0;
                    tx_d    = tx_q + 2'd1;
                    byte_d  = 5'd0;
                    stb_d   = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            byte_q     <= 5'd0;
            tx_q       <= 2'd0;
            shadow_q   <= 12'd0;
            last_val_q <= 12'd0;
            pending_q  <= 1'b1;
            stb_q      <= 1'b1;
            sclk_q     <= 1'b1;
            dio_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            shadow_q   <= shadow_d;
            last_val_q <= last_val_d;
            pending_q  <= pending_d;
            stb_q      <= stb_d;
            sclk_q     <= sclk_d;
            dio_q      <= dio_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign tm_stb = stb_q;
    assign tm_clk = sclk_q;
    assign tm_dio = dio_q;

endmodule
